vga_out_pipe: RTL and testbench

- Parametrised, pipelined successor to the video output colour-space stage.
- Takes RGB pixels plus hs/vs/de and emits either RGB passthrough or BT.601 YPbPr, limited or full range, at configurable channel width.
- Sync is delay-matched so timing is identical in every mode.
- Mode changes from the HPS UIO config byte take effect only at frame start.
- Sits between the scaler/core video mux and the VGA DAC / analog output pins.

---
 rtl/vga_out_pipe.sv | 268 ++++++++++++++++++++++++++
 tb/tb_vga_out_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_out_pipe.sv
// vga_out_pipe
//    Video output colour-space stage. Emits RGB passthrough or BT.601 YPbPr
//    (limited or full range) with a fixed three-cycle pipeline. hs/vs/de are
//    delayed by the same three cycles so output timing never depends on mode.
//    Configuration arrives as a byte over the HPS UIO bus into a shadow copy.
//    The shadow copy is made active only on a rising edge of vs_in.
//
// Ports
//    clk_sys                 pixel/system clock
//    reset                   asynchronous active-high reset
//    io_uio                  UIO transaction active
//    io_strobe               UIO byte strobe; io_din is taken on its rising edge
//    io_din[7:0]             UIO data byte
//    ypbpr_full              1 = full-range YPbPr; latched at frame start
//    din[3*DW-1:0]           {R,G,B}, R in the MSBs
//    hs_in/vs_in/de_in       active-high syncs and data enable
//    dout[3*DW-1:0]          {R|Pr, G|Y, B|Pb}
//    hs_out/vs_out/de_out    syncs delayed by LAT cycles
//    scaler                  active config bit 2
//    csync                   active config bit 3
module vga_out_pipe #(
   parameter int DW  = 8,
   parameter int LAT = 3
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              io_uio,
   input  logic              io_strobe,
   input  logic [7:0]        io_din,
   input  logic              ypbpr_full,
   input  logic [3*DW-1:0]   din,
   input  logic              hs_in,
   input  logic              vs_in,
   input  logic              de_in,
   output logic [3*DW-1:0]   dout,
   output logic              hs_out,
   output logic              vs_out,
   output logic              de_out,
   output logic              scaler,
   output logic              csync
);

   localparam int S  = DW - 8;
   // Signed internal width: holds 220 * (2^DW - 1) plus rounding without overflow.
   localparam int SW = DW + 11;

   localparam logic signed [SW-1:0] C_YR   = SW'(32'sd66);
   localparam logic signed [SW-1:0] C_YG   = SW'(32'sd129);
   localparam logic signed [SW-1:0] C_YB   = SW'(32'sd25);
   localparam logic signed [SW-1:0] C_BR   = SW'(-32'sd38);
   localparam logic signed [SW-1:0] C_BG   = SW'(-32'sd74);
   localparam logic signed [SW-1:0] C_BB   = SW'(32'sd112);
   localparam logic signed [SW-1:0] C_RR   = SW'(32'sd112);
   localparam logic signed [SW-1:0] C_RG   = SW'(-32'sd94);
   localparam logic signed [SW-1:0] C_RB   = SW'(-32'sd18);
   localparam logic signed [SW-1:0] C_RND  = SW'(32'sd128);
   localparam logic signed [SW-1:0] C_OFF_Y = SW'(32'sd16 <<< S);
   localparam logic signed [SW-1:0] C_OFF_C = SW'(32'sd128 <<< S);
   localparam logic signed [SW-1:0] C_Y_HI  = SW'(32'sd235 <<< S);
   localparam logic signed [SW-1:0] C_C_HI  = SW'(32'sd240 <<< S);
   localparam logic signed [SW-1:0] C_K_Y   = SW'(32'sd298);
   localparam logic signed [SW-1:0] C_K_C   = SW'(32'sd291);
   localparam logic signed [SW-1:0] C_MAX   = SW'((32'sd1 <<< DW) - 32'sd1);

   if (LAT != 3) begin : g_lat_check
      $error("vga_out_pipe: LAT must be 3");
   end
   if (DW < 8 || DW > 10) begin : g_dw_check
      $error("vga_out_pipe: DW must be in 8..10");
   end

   // Unsigned channel times signed coefficient, in the internal signed width.
   function automatic logic signed [SW-1:0] f_mul(input logic [DW-1:0] v,
                                                  input logic signed [SW-1:0] c);
      logic signed [SW-1:0] w_v;
      w_v = $signed({{(SW-DW){1'b0}}, v});
      return w_v * c;
   endfunction

   // Clamp a level into [lo, hi] and return it as a DW-bit code.
   function automatic logic [DW-1:0] f_clamp(input logic signed [SW-1:0] v,
                                             input logic signed [SW-1:0] lo,
                                             input logic signed [SW-1:0] hi);
      logic signed [SW-1:0] w_t;
      if (v < lo) begin
         w_t = lo;
      end else if (v > hi) begin
         w_t = hi;
      end else begin
         w_t = v;
      end
      return w_t[DW-1:0];
   endfunction

   // Expand a limited-range code to full range. The input is already clamped
   // to at least 16<<s, so the subtraction never goes negative.
   function automatic logic [DW-1:0] f_full(input logic [DW-1:0] v,
                                            input logic signed [SW-1:0] k);
      logic signed [SW-1:0] w_d;
      logic signed [SW-1:0] w_p;
      w_d = $signed({{(SW-DW){1'b0}}, v}) - C_OFF_Y;
      w_p = (w_d * k + C_RND) >>> 4'd8;
      return (w_p > C_MAX) ? C_MAX[DW-1:0] : w_p[DW-1:0];
   endfunction

   // Command parser / configuration state
   logic              r_strobe_d;
   logic              r_has_cmd;
   logic              r_cmd_wr;
   logic              r_sh_scaler, r_sh_csync, r_sh_ypbpr;
   logic              r_vs_d;
   logic              r_act_scaler, r_act_csync, r_act_ypbpr, r_act_full;

   // Pipeline state
   logic signed [SW-1:0] r_p_yr, r_p_yg, r_p_yb;
   logic signed [SW-1:0] r_p_br, r_p_bg, r_p_bb;
   logic signed [SW-1:0] r_p_rr, r_p_rg, r_p_rb;
   logic              r_s1_ypbpr, r_s1_full;
   logic [3*DW-1:0]   r_s1_pt;
   logic [2:0]        r_s1_sync;
   logic              r_s2_ypbpr, r_s2_full;
   logic [3*DW-1:0]   r_s2_pt;
   logic [DW-1:0]     r_s2_y, r_s2_pb, r_s2_pr;
   logic [2:0]        r_s2_sync;

   logic              w_strobe_rise;
   logic              w_vs_rise;
   logic [DW-1:0]     w_r, w_g, w_b;
   logic signed [SW-1:0] w_sum_y, w_sum_pb, w_sum_pr;
   logic signed [SW-1:0] w_lvl_y, w_lvl_pb, w_lvl_pr;
   logic [DW-1:0]     w_full_y, w_full_pb, w_full_pr;

   assign w_strobe_rise = io_strobe & ~r_strobe_d;
   assign w_vs_rise     = vs_in & ~r_vs_d;

   assign w_r = din[3*DW-1:2*DW];
   assign w_g = din[2*DW-1:DW];
   assign w_b = din[DW-1:0];

   // Rounding then floor shift; the offset is added after the shift.
   assign w_sum_y  = r_p_yr + r_p_yg + r_p_yb + C_RND;
   assign w_sum_pb = r_p_br + r_p_bg + r_p_bb + C_RND;
   assign w_sum_pr = r_p_rr + r_p_rg + r_p_rb + C_RND;
   assign w_lvl_y  = (w_sum_y  >>> 4'd8) + C_OFF_Y;
   assign w_lvl_pb = (w_sum_pb >>> 4'd8) + C_OFF_C;
   assign w_lvl_pr = (w_sum_pr >>> 4'd8) + C_OFF_C;

   assign w_full_y  = f_full(r_s2_y,  C_K_Y);
   assign w_full_pb = f_full(r_s2_pb, C_K_C);
   assign w_full_pr = f_full(r_s2_pr, C_K_C);

   assign scaler = r_act_scaler;
   assign csync  = r_act_csync;

   // UIO byte parser: first strobed byte is the command, later bytes under cmd 1 load the shadow.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_strobe_d  <= 1'b0;
         r_has_cmd   <= 1'b0;
         r_cmd_wr    <= 1'b0;
         r_sh_scaler <= 1'b0;
         r_sh_csync  <= 1'b0;
         r_sh_ypbpr  <= 1'b0;
      end else begin
         r_strobe_d <= io_strobe;
         if (!io_uio) begin
            r_has_cmd <= 1'b0;
         end else if (w_strobe_rise) begin
            if (!r_has_cmd) begin
               r_has_cmd <= 1'b1;
               r_cmd_wr  <= (io_din == 8'd1);
            end else if (r_cmd_wr) begin
               r_sh_scaler <= io_din[2];
               r_sh_csync  <= io_din[3];
               r_sh_ypbpr  <= io_din[5];
            end else begin
               r_has_cmd <= 1'b1;
            end
         end else begin
            r_has_cmd <= r_has_cmd;
         end
      end
   end

   // Frame-start transfer of shadow config into the active config. A shadow
   // write in the same cycle is not seen here until the next frame.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_vs_d       <= 1'b0;
         r_act_scaler <= 1'b0;
         r_act_csync  <= 1'b0;
         r_act_ypbpr  <= 1'b0;
         r_act_full   <= 1'b0;
      end else begin
         r_vs_d <= vs_in;
         if (w_vs_rise) begin
            r_act_scaler <= r_sh_scaler;
            r_act_csync  <= r_sh_csync;
            r_act_ypbpr  <= r_sh_ypbpr;
            r_act_full   <= ypbpr_full;
         end else begin
            r_act_ypbpr <= r_act_ypbpr;
         end
      end
   end

   // Stage 1: products, and mode sampled here so it travels with the pixel.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_p_yr <= '0; r_p_yg <= '0; r_p_yb <= '0;
         r_p_br <= '0; r_p_bg <= '0; r_p_bb <= '0;
         r_p_rr <= '0; r_p_rg <= '0; r_p_rb <= '0;
         r_s1_ypbpr <= 1'b0;
         r_s1_full  <= 1'b0;
         r_s1_pt    <= '0;
         r_s1_sync  <= 3'b000;
      end else begin
         r_p_yr <= f_mul(w_r, C_YR); r_p_yg <= f_mul(w_g, C_YG); r_p_yb <= f_mul(w_b, C_YB);
         r_p_br <= f_mul(w_r, C_BR); r_p_bg <= f_mul(w_g, C_BG); r_p_bb <= f_mul(w_b, C_BB);
         r_p_rr <= f_mul(w_r, C_RR); r_p_rg <= f_mul(w_g, C_RG); r_p_rb <= f_mul(w_b, C_RB);
         r_s1_ypbpr <= r_act_ypbpr;
         r_s1_full  <= r_act_full;
         r_s1_pt    <= din;
         r_s1_sync  <= {hs_in, vs_in, de_in};
      end
   end

   // Stage 2: sum, round, offset and clamp to limited-range levels.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_s2_ypbpr <= 1'b0;
         r_s2_full  <= 1'b0;
         r_s2_pt    <= '0;
         r_s2_y     <= '0;
         r_s2_pb    <= '0;
         r_s2_pr    <= '0;
         r_s2_sync  <= 3'b000;
      end else begin
         r_s2_ypbpr <= r_s1_ypbpr;
         r_s2_full  <= r_s1_full;
         r_s2_pt    <= r_s1_pt;
         r_s2_y     <= f_clamp(w_lvl_y,  C_OFF_Y, C_Y_HI);
         r_s2_pb    <= f_clamp(w_lvl_pb, C_OFF_Y, C_C_HI);
         r_s2_pr    <= f_clamp(w_lvl_pr, C_OFF_Y, C_C_HI);
         r_s2_sync  <= r_s1_sync;
      end
   end

   // Stage 3: optional full-range expansion and output mux.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         dout   <= '0;
         hs_out <= 1'b0;
         vs_out <= 1'b0;
         de_out <= 1'b0;
      end else begin
         if (!r_s2_ypbpr) begin
            dout <= r_s2_pt;
         end else if (r_s2_full) begin
            dout <= {w_full_pr, w_full_y, w_full_pb};
         end else begin
            dout <= {r_s2_pr, r_s2_y, r_s2_pb};
         end
         {hs_out, vs_out, de_out} <= r_s2_sync;
      end
   end

endmodule

// File: tb/tb_vga_out_pipe.sv
// Self-checking bench for vga_out_pipe. Two instances (DW=8 and DW=10) share
// the control inputs; a reference model derives expected outputs from the
// colour-space formulas and the frame-start config rule, and a compare
// process checks both instances on every falling clock edge.
module tb_vga_out_pipe;

   logic        clk_sys = 1'b0;
   logic        reset, io_uio, io_strobe, ypbpr_full, hs_in, vs_in, de_in;
   logic [7:0]  io_din;
   logic [23:0] din8;
   logic [29:0] din10;

   logic [23:0] dout8;
   logic [29:0] dout10;
   logic        hs8, vs8, de8, scaler8, csync8;
   logic        hs10, vs10, de10, scaler10, csync10;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   always #5 clk_sys = ~clk_sys;

   vga_out_pipe #(.DW(8), .LAT(3)) u_dut8 (
      .clk_sys(clk_sys), .reset(reset), .io_uio(io_uio), .io_strobe(io_strobe),
      .io_din(io_din), .ypbpr_full(ypbpr_full), .din(din8),
      .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
      .dout(dout8), .hs_out(hs8), .vs_out(vs8), .de_out(de8),
      .scaler(scaler8), .csync(csync8));

   vga_out_pipe #(.DW(10), .LAT(3)) u_dut10 (
      .clk_sys(clk_sys), .reset(reset), .io_uio(io_uio), .io_strobe(io_strobe),
      .io_din(io_din), .ypbpr_full(ypbpr_full), .din(din10),
      .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
      .dout(dout10), .hs_out(hs10), .vs_out(vs10), .de_out(de10),
      .scaler(scaler10), .csync(csync10));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clampi(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   // Expected output word {Pr,Y,Pb} (or {R,G,B}) for one pixel.
   function automatic logic [29:0] exp_pix(input int r, input int g, input int b,
                                           input int dw, input bit ypbpr, input bit full);
      int s, y, pb, pr, mx;
      if (!ypbpr) return (30'(r) << (2*dw)) | (30'(g) << dw) | 30'(b);
      s  = dw - 8;
      y  = ((66*r + 129*g + 25*b + 128) >>> 8) + (16 << s);
      pb = ((-38*r - 74*g + 112*b + 128) >>> 8) + (128 << s);
      pr = ((112*r - 94*g - 18*b + 128) >>> 8) + (128 << s);
      y  = clampi(y,  16 << s, 235 << s);
      pb = clampi(pb, 16 << s, 240 << s);
      pr = clampi(pr, 16 << s, 240 << s);
      if (full) begin
         mx = (1 << dw) - 1;
         y  = clampi(((y  - (16 << s)) * 298 + 128) >>> 8, 0, mx);
         pb = clampi(((pb - (16 << s)) * 291 + 128) >>> 8, 0, mx);
         pr = clampi(((pr - (16 << s)) * 291 + 128) >>> 8, 0, mx);
      end
      return (30'(pr) << (2*dw)) | (30'(y) << dw) | 30'(pb);
   endfunction

   // Reference model state
   logic [29:0] h8 [3];
   logic [29:0] h10[3];
   logic [2:0]  hsy[3];
   logic [7:0]  m_shadow, m_act, m_cmd;
   bit          m_full, m_vs_prev, m_stb_prev;
   int          m_idx;

   initial begin
      forever begin
         @(posedge clk_sys);
         if (reset) begin
            for (int i = 0; i < 3; i++) begin
               h8[i] = '0; h10[i] = '0; hsy[i] = '0;
            end
            m_shadow = 8'h00; m_act = 8'h00; m_cmd = 8'h00; m_full = 1'b0;
            m_vs_prev = 1'b0; m_stb_prev = 1'b0; m_idx = 0;
         end else begin
            h8[2] = h8[1]; h8[1] = h8[0];
            h10[2] = h10[1]; h10[1] = h10[0];
            hsy[2] = hsy[1]; hsy[1] = hsy[0];
            h8[0]  = exp_pix(int'(din8[23:16]), int'(din8[15:8]), int'(din8[7:0]), 8, m_act[5], m_full);
            h10[0] = exp_pix(int'(din10[29:20]), int'(din10[19:10]), int'(din10[9:0]), 10, m_act[5], m_full);
            hsy[0] = {hs_in, vs_in, de_in};
            // frame start uses the shadow as it was before this edge
            if (vs_in && !m_vs_prev) begin
               m_act  = m_shadow;
               m_full = ypbpr_full;
            end
            m_vs_prev = vs_in;
            if (!io_uio) begin
               m_idx = 0;
            end else if (io_strobe && !m_stb_prev) begin
               if (m_idx == 0) m_cmd = io_din;
               else if (m_cmd == 8'd1) m_shadow = io_din;
               m_idx++;
            end
            m_stb_prev = io_strobe;
         end
      end
   end

   // Per-cycle compare of both instances against the model.
   initial begin
      forever begin
         @(negedge clk_sys);
         if (chk_en) begin
            chk("dout8",  {8'h00, dout8}, {2'b00, h8[2]});
            chk("dout10", {2'b00, dout10}, {2'b00, h10[2]});
            chk("sync8",  {29'd0, hs8, vs8, de8}, {29'd0, hsy[2]});
            chk("sync10", {29'd0, hs10, vs10, de10}, {29'd0, hsy[2]});
            chk("cfg8",   {30'd0, scaler8, csync8}, {30'd0, m_act[2], m_act[3]});
            chk("cfg10",  {30'd0, scaler10, csync10}, {30'd0, m_act[2], m_act[3]});
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic uio_byte(input logic [7:0] b);
      io_din = b; io_strobe = 1'b1; step(1);
      io_strobe = 1'b0; step(1);
   endtask

   task automatic vs_edge();
      vs_in = 1'b1; step(1);
      vs_in = 1'b0; step(1);
   endtask

   task automatic write_cfg(input logic [7:0] b);
      io_uio = 1'b1; step(1);
      uio_byte(8'h01); uio_byte(b);
      io_uio = 1'b0; step(1);
   endtask

   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      // model pins against hand-computed values
      chk("pin_black",  {2'b0, exp_pix(0, 0, 0, 8, 1'b1, 1'b0)},       32'h801080);
      chk("pin_white",  {2'b0, exp_pix(255, 255, 255, 8, 1'b1, 1'b0)}, 32'h80EB80);
      chk("pin_red",    {2'b0, exp_pix(255, 0, 0, 8, 1'b1, 1'b0)},     32'hF0525A);
      chk("pin_fwhite", {2'b0, exp_pix(255, 255, 255, 8, 1'b1, 1'b1)}, 32'h7FFF7F);
      chk("pin_fred",   {2'b0, exp_pix(255, 0, 0, 8, 1'b1, 1'b1)},     32'hFF4D54);
      chk("pin_y940",   {2'b0, exp_pix(1023, 1023, 1023, 10, 1'b1, 1'b0)},
          {2'b0, 10'd512, 10'd940, 10'd512});

      reset = 1'b1; io_uio = 1'b0; io_strobe = 1'b0; io_din = 8'h00;
      ypbpr_full = 1'b0; hs_in = 1'b0; vs_in = 1'b0; de_in = 1'b1;
      din8 = 24'h123456; din10 = 30'h0ABCDEF1;
      step(3);
      chk("rst_dout", {8'h00, dout8}, 32'h0);
      chk("rst_de", {31'd0, de8}, 32'd0);
      chk("rst_scaler", {31'd0, scaler8}, 32'd0);

      // latency from reset release
      reset = 1'b0; chk_en = 1'b1;
      step(1);
      chk("lat1_dout", {8'h00, dout8}, 32'h0);
      step(1);
      chk("lat2_dout", {8'h00, dout8}, 32'h0);
      chk("lat2_de", {31'd0, de8}, 32'd0);
      step(1);
      chk("lat3_dout", {8'h00, dout8}, 32'h123456);
      chk("lat3_de", {31'd0, de8}, 32'd1);

      // config written mid-frame is deferred to the next vs rise
      din8 = 24'hFFFFFF; din10 = 30'h3FFFFFFF;
      write_cfg(8'h2C);
      step(2);
      chk("defer_scaler", {31'd0, scaler8}, 32'd0);
      chk("defer_csync", {31'd0, csync8}, 32'd0);
      chk("defer_mode", {8'h00, dout8}, 32'hFFFFFF);
      vs_in = 1'b1; step(1);
      chk("edge_scaler", {31'd0, scaler8}, 32'd1);
      chk("edge_csync", {31'd0, csync8}, 32'd1);
      step(1); vs_in = 1'b0; step(1);
      chk("edge_oldmode", {8'h00, dout8}, 32'hFFFFFF);
      step(1);
      chk("lim_white", {8'h00, dout8}, 32'h80EB80);
      din8 = 24'h000000; din10 = 30'h0; step(3);
      chk("lim_black", {8'h00, dout8}, 32'h801080);
      din8 = 24'hFF0000; din10 = {10'h3FF, 20'h0}; step(3);
      chk("lim_red", {8'h00, dout8}, 32'hF0525A);

      // full range
      ypbpr_full = 1'b1; din8 = 24'hFFFFFF; din10 = 30'h3FFFFFFF;
      vs_in = 1'b1; step(1); vs_in = 1'b0; step(3);
      chk("full_white", {8'h00, dout8}, 32'h7FFF7F);
      din8 = 24'h000000; din10 = 30'h0; step(3);
      chk("full_black", {8'h00, dout8}, 32'h7F007F);
      din8 = 24'hFF0000; step(3);
      chk("full_red", {8'h00, dout8}, 32'hFF4D54);

      // shadow write coincident with vs rise is taken one frame later
      io_uio = 1'b1; step(1);
      uio_byte(8'h01);
      io_din = 8'h00; io_strobe = 1'b1; vs_in = 1'b1; step(1);
      chk("coinc_scaler", {31'd0, scaler8}, 32'd1);
      io_strobe = 1'b0; vs_in = 1'b0; io_uio = 1'b0; step(2);
      vs_in = 1'b1; step(1);
      chk("coinc_next", {31'd0, scaler8}, 32'd0);
      vs_in = 1'b0; step(1);

      // non-1 command leaves shadow alone
      io_uio = 1'b1; step(1);
      uio_byte(8'h02); uio_byte(8'hFF);
      io_uio = 1'b0; step(1);
      vs_edge();
      chk("cmd2_scaler", {31'd0, scaler8}, 32'd0);
      chk("cmd2_csync", {31'd0, csync8}, 32'd0);

      // bytes after io_uio drops are ignored
      io_uio = 1'b1; step(1);
      uio_byte(8'h01);
      io_uio = 1'b0; step(1);
      uio_byte(8'h2C); uio_byte(8'h2C);
      vs_edge();
      chk("drop_scaler", {31'd0, scaler8}, 32'd0);

      // held strobe captures only one byte
      io_uio = 1'b1; step(1);
      uio_byte(8'h01);
      io_din = 8'h04; io_strobe = 1'b1; step(1);
      io_din = 8'h2C; step(3);
      io_strobe = 1'b0; step(1);
      io_uio = 1'b0; step(1);
      vs_edge();
      chk("held_scaler", {31'd0, scaler8}, 32'd1);
      chk("held_csync", {31'd0, csync8}, 32'd0);

      // random sweep, limited then full, occasional vs edges
      write_cfg(8'h20);
      for (int pass = 0; pass < 2; pass++) begin
         ypbpr_full = pass[0];
         vs_edge();
         for (int i = 0; i < 150; i++) begin
            din8  = 24'($urandom);
            din10 = 30'($urandom);
            hs_in = 1'($urandom);
            de_in = 1'($urandom);
            vs_in = ($urandom_range(0, 15) == 0);
            step(1);
         end
         vs_in = 1'b0; step(1);
      end

      // all-ones at DW=10, limited
      ypbpr_full = 1'b0; din10 = 30'h3FFFFFFF; din8 = 24'hFFFFFF;
      vs_edge(); step(3);
      chk("y940", {22'd0, dout10[19:10]}, 32'd940);
      chk("ones8", {8'h00, dout8}, 32'h80EB80);

      // reset mid-frame clears outputs immediately
      #2 reset = 1'b1;
      #1;
      chk("midrst_dout", {8'h00, dout8}, 32'h0);
      chk("midrst_scaler", {31'd0, scaler8}, 32'd0);
      step(2);
      reset = 1'b0;
      step(4);
      chk("post_rst_pt", {8'h00, dout8}, 32'hFFFFFF);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
